// File: rtl/bit_flip_decode.sv
// -----------------------------------------------------------------------------
// bit_flip_decode
//   Iterative hard-decision LDPC bit-flipping decoder. A received word and its
//   parity-check matrix H are latched on i_start. Each CHECK cycle computes the
//   syndrome. If it is zero, or the flip budget is used up, the decode ends.
//   Otherwise every bit involved in the largest number of unsatisfied checks is
//   flipped, and the syndrome is evaluated again on the next cycle.
//
// Ports
//   clk            : rising-edge clock
//   i_rst_n        : asynchronous active-low reset
//   i_start        : start a decode; sampled only while idle
//   i_received     : N-bit hard-decision received word (bit i = codeword bit i)
//   i_parity_check : H flattened row-major, H[r][i] = i_parity_check[r*N + i]
//   o_codeword     : decoded word, updated with o_done and held
//   o_busy         : high from the cycle after start acceptance until o_done
//   o_done         : one-cycle pulse, results valid
//   o_success      : final syndrome was zero; updated with o_done and held
//   o_iter         : number of flip iterations used; updated with o_done and held
// -----------------------------------------------------------------------------
module bit_flip_decode #(
    parameter  int N        = 6,
    parameter  int M        = 3,
    parameter  int MAX_ITER = 8,
    localparam int ITER_W   = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1,
    localparam int CNT_W    = (M > 0) ? $clog2(M + 1) : 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [N-1:0]      i_received,
    input  logic [M*N-1:0]    i_parity_check,
    output logic [N-1:0]      o_codeword,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_success,
    output logic [ITER_W-1:0] o_iter
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [N-1:0]      word;
    logic [M*N-1:0]    h_q;
    logic [ITER_W-1:0] iter;
    logic              success;

    logic [M-1:0]      syn;
    logic [CNT_W-1:0]  cnt [N];
    logic [CNT_W-1:0]  maxc;
    logic [N-1:0]      flip;

    // Syndrome of the working word against the latched H.
    always_comb begin
        syn = '0;
        for (int unsigned r = 0; r < M; r++) begin
            for (int unsigned i = 0; i < N; i++) begin
                syn[r] = syn[r] ^ (word[i] & h_q[r*N + i]);
            end
        end
    end

    // Per-bit count of unsatisfied checks, the maximum count, and the flip mask.
    // Every bit that ties for the maximum is flipped. When the syndrome is
    // nonzero, maxc is never zero, so the mask is never empty in that case.
    always_comb begin
        maxc = '0;
        flip = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt[i] = '0;
            for (int unsigned r = 0; r < M; r++) begin
                if (syn[r] && h_q[r*N + i]) begin
                    cnt[i] = cnt[i] + CNT_W'(1);
                end
            end
            if (cnt[i] > maxc) begin
                maxc = cnt[i];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            flip[i] = (cnt[i] == maxc);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            word       <= '0;
            h_q        <= '0;
            iter       <= '0;
            success    <= 1'b0;
            o_codeword <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_success  <= 1'b0;
            o_iter     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        word   <= i_received;
                        h_q    <= i_parity_check;
                        iter   <= '0;
                        o_busy <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (syn == '0) begin
                        success <= 1'b1;
                        state   <= S_DONE;
                    end else if (iter == ITER_W'(MAX_ITER)) begin
                        success <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        word <= word ^ flip;
                        iter <= iter + ITER_W'(1);
                    end
                end
                S_DONE: begin
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    o_codeword <= word;
                    o_success  <= success;
                    o_iter     <= iter;
                    state      <= S_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_flip_decode.sv
// -----------------------------------------------------------------------------
// tb_bit_flip_decode
//   Directed bench for bit_flip_decode (N=6, M=3, MAX_ITER=8, H = 18'h264CD).
//   The expected words, flip counts and latencies are worked out by hand from
//   the H rows 6'h0D, 6'h13 and 6'h26.
// -----------------------------------------------------------------------------
module tb_bit_flip_decode;

    localparam int N        = 6;
    localparam int M        = 3;
    localparam int MAX_ITER = 8;
    localparam int IW       = 4;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [N-1:0]  i_received;
    logic [M*N-1:0] i_parity_check;
    logic [N-1:0]  o_codeword;
    logic          o_busy;
    logic          o_done;
    logic          o_success;
    logic [IW-1:0] o_iter;

    int checks  = 0;
    int passes  = 0;
    int cyc     = 0;
    int t_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_flip_decode #(
        .N        (N),
        .M        (M),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_received     (i_received),
        .i_parity_check (i_parity_check),
        .o_codeword     (o_codeword),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_success      (o_success),
        .o_iter         (o_iter)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Raise i_start now; it is sampled on the next rising edge.
    task automatic start_now(input string tag, input logic [N-1:0] w);
        i_received = w;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        t_start    = cyc;
        i_start    = 1'b0;
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
    endtask

    task automatic start_word(input string tag, input logic [N-1:0] w);
        @(negedge clk);
        start_now(tag, w);
    endtask

    // Wait for o_done, with a bound, then check the results and the latency
    // counted in edges from the edge that accepted the start.
    task automatic expect_result(input string tag, input logic [N-1:0] cw,
                                 input logic succ, input logic [IW-1:0] it,
                                 input int lat);
        logic seen;
        seen = 1'b0;
        while (!seen && (cyc - t_start) < 20) begin
            @(posedge clk);
            #1;
            if (o_done) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc - t_start), 32'(lat));
        check({tag, "_cw"}, 32'(o_codeword), 32'(cw));
        check({tag, "_succ"}, 32'(o_success), 32'(succ));
        check({tag, "_iter"}, 32'(o_iter), 32'(it));
        check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic any_done;
        i_rst_n        = 1'b0;
        i_start        = 1'b0;
        i_received     = '0;
        i_parity_check = 18'h264CD;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cw",   32'(o_codeword), 32'd0);
        check("rst_busy", 32'(o_busy),     32'd0);
        check("rst_done", 32'(o_done),     32'd0);
        check("rst_succ", 32'(o_success),  32'd0);
        check("rst_iter", 32'(o_iter),     32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Clean word
        start_word("c1", 6'h35);
        expect_result("c1", 6'h35, 1'b1, 4'd0, 2);

        // Single error on bit 0
        start_word("c2", 6'h34);
        expect_result("c2", 6'h35, 1'b1, 4'd1, 3);

        // Double error, converges to another codeword
        start_word("c3", 6'h36);
        expect_result("c3", 6'h32, 1'b1, 4'd1, 3);

        // Oscillating word: runs out of iterations
        start_word("c4", 6'h3F);
        expect_result("c4", 6'h3F, 1'b0, 4'd8, 10);

        // A start pulse while busy is dropped, even with different inputs
        start_word("c5a", 6'h3F);
        @(negedge clk);
        i_start        = 1'b1;
        i_received     = 6'h35;
        i_parity_check = '0;
        @(negedge clk);
        i_start        = 1'b0;
        i_parity_check = 18'h264CD;
        expect_result("c5a", 6'h3F, 1'b0, 4'd8, 10);

        // Start raised during the o_done cycle is accepted on the next edge
        start_now("c5b", 6'h34);
        check("c5b_done_cleared", 32'(o_done), 32'd0);
        expect_result("c5b", 6'h35, 1'b1, 4'd1, 3);

        // Reset in the middle of a long decode
        start_word("c6", 6'h3F);
        repeat (4) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        check("c6_rst_cw",   32'(o_codeword), 32'd0);
        check("c6_rst_busy", 32'(o_busy),     32'd0);
        check("c6_rst_done", 32'(o_done),     32'd0);
        check("c6_rst_succ", 32'(o_success),  32'd0);
        check("c6_rst_iter", 32'(o_iter),     32'd0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        any_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            any_done = any_done | o_done;
        end
        check("c6_no_done", 32'(any_done), 32'd0);
        check("c6_idle_busy", 32'(o_busy), 32'd0);

        start_word("c6r", 6'h35);
        expect_result("c6r", 6'h35, 1'b1, 4'd0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
